// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EXE stage, producing one HI/LO write per op.
// Latency: multiply MUL_LAT+2 stall cycles, divide DIV_ITER+2 stall cycles, then DONE until exe_adv.
// Backpressure: stall_out holds the front end while working; DONE waits on exe_adv; flush aborts.
module mdu_sequencer #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    input  logic        exe_adv,
    output logic        stall_out,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [63:0]      acc_q;
    logic [63:0]      prod_q;
    logic [31:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dvs_q;
    logic             first_q;

    logic             accept;
    logic             op_is_div;
    logic             op_div_signed;
    logic             last_mul;
    logic             last_div;

    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic [32:0]      div_shift;
    logic             div_ge;
    logic [31:0]      rem_nxt;
    logic [31:0]      quo_nxt;

    logic             a_neg;
    logic             b_neg;
    logic [31:0]      q_fix;
    logic [31:0]      r_fix;
    logic [63:0]      fix_res;

    // ops 2/3 are the divides; bit 0 clear means signed
    assign op_is_div     = (op[2:1] == 2'b01);
    assign op_div_signed = op_is_div & ~op[0];
    assign accept        = (state_q == S_IDLE) && op_valid && !flush;
    assign last_mul      = (cnt_q == CNT_W'(MUL_LAT - 1));
    assign last_div      = (cnt_q == CNT_W'(DIV_ITER - 1));
    assign busy          = (state_q != S_IDLE);

    // Operand extension, one restoring-divide step, and the final sign/accumulate fix-up
    always_comb begin
        mul_a     = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
        mul_b     = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};

        div_shift = {rem_q, quo_q[31]};
        div_ge    = (div_shift >= {1'b0, dvs_q});
        rem_nxt   = div_ge ? (div_shift[31:0] - dvs_q) : div_shift[31:0];
        quo_nxt   = {quo_q[30:0], div_ge};

        a_neg     = ~op_q[0] & a_q[31];
        b_neg     = ~op_q[0] & b_q[31];
        q_fix     = (a_neg ^ b_neg) ? (32'd0 - quo_q) : quo_q;
        r_fix     = a_neg ? (32'd0 - rem_q) : rem_q;
        // divide by zero: all-ones quotient, dividend passed through as remainder
        if (b_q == 32'd0) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = a_q;
        end

        case (op_q[2:1])
            2'b01:   fix_res = {r_fix, q_fix};
            2'b10:   fix_res = acc_q + prod_q;
            2'b11:   fix_res = acc_q - prod_q;
            default: fix_res = prod_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and write strobe; flush overrides everything
    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        hilo_we   = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        stall_out = 1'b1;
                        state_d   = op_is_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    stall_out = 1'b1;
                    if (last_mul) state_d = S_FIX;
                end
                S_DIV: begin
                    stall_out = 1'b1;
                    if (last_div) state_d = S_FIX;
                end
                S_FIX: begin
                    stall_out = 1'b1;
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    hilo_we = first_q;
                    if (exe_adv) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration counter, multiply/divide progress, result register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            first_q <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            first_q <= (state_q == S_FIX) && !flush;
            if (accept) begin
                cnt_q <= '0;
                op_q  <= op;
                a_q   <= src_a;
                b_q   <= src_b;
                acc_q <= {hi_in, lo_in};
                rem_q <= '0;
                quo_q <= (op_div_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
                dvs_q <= (op_div_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
            end else begin
                case (state_q)
                    S_MUL: begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        prod_q <= mul_a * mul_b;
                    end
                    S_DIV: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                    end
                    S_FIX: begin
                        if (!flush) begin
                            hi_out <= fix_res[63:32];
                            lo_out <= fix_res[31:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and randomised bench for mdu_sequencer with an expected-result queue.
// Latency: checks exact stall-cycle counts per op class.
// Backpressure: exercises DONE hold via exe_adv, flush aborts and async reset.
module tb_mdu_sequencer;

    localparam int MUL_STALL = 4;
    localparam int DIV_STALL = 34;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        flush;
    logic        exe_adv;
    logic        stall_out;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_count = 0;
    logic [63:0] sb_q[$];

    mdu_sequencer #(.MUL_LAT(2), .DIV_ITER(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .flush    (flush),
        .exe_adv  (exe_adv),
        .stall_out(stall_out),
        .hilo_we  (hilo_we),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count write strobes mid-cycle
    always @(negedge clk) if (hilo_we === 1'b1) we_count <= we_count + 1;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        if (o == 3'd2 || o == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (o == 3'd2) begin
                sa  = longint'($signed(a));
                sbv = longint'($signed(b));
            end else begin
                sa  = longint'({32'b0, a});
                sbv = longint'({32'b0, b});
            end
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
        end
        ea = o[0] ? {32'b0, a} : {{32{a[31]}}, a};
        eb = o[0] ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        case (o[2:1])
            2'b10:   return {h, l} + p;
            2'b11:   return {h, l} - p;
            default: return p;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        @(posedge clk); #1;
        op_valid = 1'b1; op = o; src_a = a; src_b = b; hi_in = h; lo_in = l;
        #1;
    endtask

    // count stall cycles from the accept cycle; scramble operands after accept
    task automatic wait_done(output int stalls);
        stalls = 0;
        while (stall_out === 1'b1 && stalls < 100) begin
            stalls++;
            @(posedge clk); #1;
            op_valid = 1'b0;
            src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input logic [63:0] exp_res,
                          input int exp_stall, input int hold);
        int          st;
        int          wc0;
        logic [63:0] exp;
        wc0 = we_count;
        issue(o, a, b, h, l);
        sb_q.push_back(exp_res);
        wait_done(st);
        check({tag, " stalls"}, 64'(st), 64'(exp_stall));
        check({tag, " we"}, 64'(hilo_we), 64'd1);
        exp = sb_q.pop_front();
        check({tag, " result"}, {hi_out, lo_out}, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            check({tag, " hold we"}, 64'(hilo_we), 64'd0);
            check({tag, " hold busy"}, 64'(busy), 64'd1);
            check({tag, " hold result"}, {hi_out, lo_out}, exp);
        end
        exe_adv = 1'b1;
        @(posedge clk); #1;
        exe_adv = 1'b0;
        #1;
        check({tag, " idle"}, 64'(busy), 64'd0);
        check({tag, " we count"}, 64'(we_count - wc0), 64'd1);
    endtask

    initial begin
        int          st;
        int          wc0;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] rh;
        logic [31:0] rl;

        resetn = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        hi_in = '0; lo_in = '0; flush = 1'b0; exe_adv = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset stall", 64'(stall_out), 64'd0);
        check("reset we", 64'(hilo_we), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi_out, lo_out}, 64'd0);
        resetn = 1'b1;

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFA, MUL_STALL, 0);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'hFFFF_FFFE_0000_0001, MUL_STALL, 0);
        run_op("madd", 3'd4, 32'hFFFF_FFFF, 32'd5, 32'h0, 32'd10, 64'd5, MUL_STALL, 0);
        run_op("msubu", 3'd7, 32'd2, 32'd3, 32'h0, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, MUL_STALL, 0);
        run_op("maddu", 3'd5, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF, 64'h0000_0002_FFFF_FFFF, MUL_STALL, 0);
        run_op("msub", 3'd6, 32'hFFFF_FFFD, 32'd4, 32'h0, 32'h0, 64'd12, MUL_STALL, 0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 32'h0, 32'h0, {32'd2, 32'd14}, DIV_STALL, 0);
        run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFD, DIV_STALL, 0);
        run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'h0000_0000_8000_0000, DIV_STALL, 0);
        run_op("divu zero", 3'd3, 32'd9, 32'd0, 32'h0, 32'h0, {32'd9, 32'hFFFF_FFFF}, DIV_STALL, 0);
        run_op("div negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0, {32'd1, 32'hFFFF_FFFD}, DIV_STALL, 0);
        run_op("done hold", 3'd0, 32'd6, 32'd7, 32'h0, 32'h0, 64'd42, MUL_STALL, 3);

        // flush during divide iteration 10
        wc0 = we_count;
        issue(3'd3, 32'd1000, 32'd3, 32'h0, 32'h0);
        repeat (10) begin
            @(posedge clk); #1;
            op_valid = 1'b0;
            #1;
        end
        check("flush pre busy", 64'(busy), 64'd1);
        flush = 1'b1;
        #1;
        check("flush stall", 64'(stall_out), 64'd0);
        check("flush we", 64'(hilo_we), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush idle", 64'(busy), 64'd0);
        check("flush idle stall", 64'(stall_out), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        check("flush no write", 64'(we_count - wc0), 64'd0);
        run_op("after flush", 3'd3, 32'd1000, 32'd3, 32'h0, 32'h0, {32'd1, 32'd333}, DIV_STALL, 0);

        // flush in the first DONE cycle
        wc0 = we_count;
        issue(3'd1, 32'd5, 32'd5, 32'h0, 32'h0);
        wait_done(st);
        check("done flush stalls", 64'(st), 64'(MUL_STALL));
        flush = 1'b1;
        #1;
        check("done flush we", 64'(hilo_we), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("done flush idle", 64'(busy), 64'd0);
        check("done flush no write", 64'(we_count - wc0), 64'd0);

        // flush together with op_valid: not accepted
        @(posedge clk); #1;
        op_valid = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd3; flush = 1'b1;
        #1;
        check("flush accept stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0;
        #1;
        check("flush accept busy", 64'(busy), 64'd0);

        // async reset mid-divide
        wc0 = we_count;
        issue(3'd2, 32'd77, 32'd5, 32'h0, 32'h0);
        repeat (5) begin
            @(posedge clk); #1;
            op_valid = 1'b0;
            #1;
        end
        #1;
        resetn = 1'b0;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst stall", 64'(stall_out), 64'd0);
        check("arst hilo", {hi_out, lo_out}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("arst no write", 64'(we_count - wc0), 64'd0);

        // random ops against the reference model
        for (int k = 0; k < 10; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom; rh = $urandom; rl = $urandom;
            if (k == 3) rb = 32'd0;
            run_op("rand", ro, ra, rb, rh, rl, model(ro, ra, rb, rh, rl),
                   (ro == 3'd2 || ro == 3'd3) ? DIV_STALL : MUL_STALL, k % 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
